// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Brief    : Shared frame geometry, metric defaults and FSM state type for
//            the rate-1/2 K=3 Viterbi front end.
// Revision : 1.0
// ============================================================================
package viterbi_pkg;

  localparam int MSG_LEN         = 7;
  localparam int CODE_LEN        = 2 * MSG_LEN;
  localparam int MET_W           = 4;
  localparam int ERR_THRESH_DEF  = 3;
  localparam int DEC_TIMEOUT_DEF = 15;
  localparam int TMO_W           = 5;
  localparam int IDX_W           = $clog2(CODE_LEN);
  localparam int BITCNT_W        = $clog2(MSG_LEN);

  typedef logic [CODE_LEN-1:0] code_t;
  typedef logic [MSG_LEN-1:0]  msg_t;
  typedef logic [MET_W-1:0]    metric_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/viterbi_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_ctrl_if
// Brief    : Bit source, decoder handshake and sink signals of the frame
//            controller; slave = controller side, master = environment side.
// Revision : 1.0
// ============================================================================
interface viterbi_frame_ctrl_if;
  import viterbi_pkg::*;

  logic    in_bit;
  logic    in_valid;
  logic    frame_sync;
  logic    dec_start;
  code_t   dec_code;
  logic    dec_done;
  msg_t    dec_data;
  metric_t dec_metric;
  logic    out_bit;
  logic    out_valid;
  logic    out_first;
  logic    bad_frame;
  logic    frame_err;
  logic    overflow;
  logic    busy;

  modport slave (
    input  in_bit, in_valid, frame_sync, dec_done, dec_data, dec_metric,
    output dec_start, dec_code, out_bit, out_valid, out_first, bad_frame,
           frame_err, overflow, busy
  );

  modport master (
    output in_bit, in_valid, frame_sync, dec_done, dec_data, dec_metric,
    input  dec_start, dec_code, out_bit, out_valid, out_first, bad_frame,
           frame_err, overflow, busy
  );

endinterface
`default_nettype wire

// File: rtl/viterbi_frame_asm.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_asm
// Brief    : Serial-to-parallel coded frame assembler with sync-slip detect
//            and a combinational completion strobe on the last bit.
// Revision : 1.0
// ============================================================================
module viterbi_frame_asm
  import viterbi_pkg::*;
(
  input  wire logic clk1,
  input  wire logic reset,
  input  wire logic i_in_bit,
  input  wire logic i_in_valid,
  input  wire logic i_frame_sync,
  output code_t     o_frame_data,
  output logic      o_frame_done,
  output logic      o_sync_slip
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(CODE_LEN - 1);

  logic [IDX_W-1:0]    r_idx;
  logic [CODE_LEN-2:0] r_shift;
  logic                w_last;

  // The final bit is never stored; it is merged straight into the frame so
  // the holding buffer can take it on the same edge.
  always_comb begin
    w_last       = (r_idx == c_last_idx);
    o_frame_done = i_in_valid && !i_frame_sync && w_last;
    o_sync_slip  = i_in_valid && i_frame_sync && (r_idx != '0);
    o_frame_data = {i_in_bit, r_shift};
  end

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_in_valid) begin
      if (i_frame_sync) begin
        r_shift <= {{(CODE_LEN-2){1'b0}}, i_in_bit};
        r_idx   <= IDX_W'(1);
      end else if (w_last) begin
        r_idx   <= '0;
      end else begin
        r_shift[r_idx] <= i_in_bit;
        r_idx          <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_ctrl
// Brief    : Frame sequencer: assembles coded frames, double-buffers them,
//            runs the decoder start/done handshake and serializes results.
// Revision : 1.0
// ============================================================================
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int ERR_THRESH  = ERR_THRESH_DEF,
  parameter int DEC_TIMEOUT = DEC_TIMEOUT_DEF
) (
  input wire logic            clk1,
  input wire logic            reset,
  viterbi_frame_ctrl_if.slave bus
);

  localparam logic [TMO_W-1:0]    c_tmo_last = TMO_W'(DEC_TIMEOUT - 1);
  localparam logic [BITCNT_W-1:0] c_bit_last = BITCNT_W'(MSG_LEN - 1);
  localparam metric_t             c_thresh   = MET_W'(ERR_THRESH);

  code_t                w_frame;
  logic                 w_frame_done;
  logic                 w_slip;

  ctrl_state_t          r_state;
  ctrl_state_t          w_state_next;
  logic                 w_dispatch;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_accept;
  logic                 w_last_bit;
  logic                 w_draining;

  logic                 r_held_v;
  code_t                r_held;
  logic                 r_dec_start;
  code_t                r_dec_code;
  logic [TMO_W-1:0]     r_wait_cnt;
  msg_t                 r_word;
  logic                 r_bad;
  logic [BITCNT_W-1:0]  r_bit_cnt;
  logic                 r_frame_err;
  logic                 r_overflow;

  viterbi_frame_asm u_asm (
    .clk1         (clk1),
    .reset        (reset),
    .i_in_bit     (bus.in_bit),
    .i_in_valid   (bus.in_valid),
    .i_frame_sync (bus.frame_sync),
    .o_frame_data (w_frame),
    .o_frame_done (w_frame_done),
    .o_sync_slip  (w_slip)
  );

  always_ff @(posedge clk1) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // DRAIN hands straight over to WAIT on its last bit when a frame is held,
  // so dec_start can follow the final out_valid cycle with no gap.
  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_last_bit   = (r_bit_cnt == c_bit_last);
    case (r_state)
      IDLE: begin
        if (r_held_v) begin
          w_dispatch   = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.dec_done) begin
          w_capture    = 1'b1;
          w_state_next = DRAIN;
        end else if (r_wait_cnt == c_tmo_last) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        if (w_last_bit) begin
          if (r_held_v) begin
            w_dispatch   = 1'b1;
            w_state_next = WAIT;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_accept = w_frame_done && (!r_held_v || w_dispatch);
  end

  always_ff @(posedge clk1) begin
    if (!reset) begin
      r_held_v    <= 1'b0;
      r_held      <= '0;
      r_dec_start <= 1'b0;
      r_dec_code  <= '0;
      r_wait_cnt  <= '0;
      r_word      <= '0;
      r_bad       <= 1'b0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_dec_start <= w_dispatch;
      if (w_dispatch) r_dec_code <= r_held;
      r_held_v <= w_accept || (r_held_v && !w_dispatch);
      if (w_accept) r_held <= w_frame;
      // Counter restarts whenever WAIT is entered from another state.
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_capture) begin
        r_word <= bus.dec_data;
        r_bad  <= (bus.dec_metric > c_thresh);
      end else if (r_state == DRAIN) begin
        r_word <= {r_word[MSG_LEN-2:0], 1'b0};
      end
      r_bit_cnt   <= (r_state == DRAIN) ? r_bit_cnt + 1'b1 : '0;
      r_frame_err <= w_slip || w_timeout;
      r_overflow  <= w_frame_done && !w_accept;
    end
  end

  assign w_draining    = (r_state == DRAIN);
  assign bus.dec_start = r_dec_start;
  assign bus.dec_code  = r_dec_code;
  assign bus.out_valid = w_draining;
  assign bus.out_bit   = w_draining && r_word[MSG_LEN-1];
  assign bus.out_first = w_draining && (r_bit_cnt == '0);
  assign bus.bad_frame = w_draining && (r_bit_cnt == '0) && r_bad;
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = (r_state != IDLE) || r_held_v;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_frame_ctrl
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a queue-based behavioural model of the frame controller.
// Revision : 1.0
// ============================================================================
module tb_viterbi_frame_ctrl;
  import viterbi_pkg::*;

  logic clk1  = 1'b0;
  logic reset = 1'b0;
  always #5 clk1 = ~clk1;

  viterbi_frame_ctrl_if bus ();

  viterbi_frame_ctrl dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // decoder stub and reset control
  int      st_lat   = -1;
  int      st_cd    = 0;
  bit      st_force = 1'b0;
  bit      st_rst_n = 1'b0;
  msg_t    st_data  = '0;
  metric_t st_met   = '0;

  // behavioural model
  int     m_idx      = 0;
  code_t  m_bits     = '0;
  bit     m_held_v   = 1'b0;
  code_t  m_held     = '0;
  int     m_wait_age = -1;
  bit     m_drain_q[$];
  bit     m_first    = 1'b0;
  bit     m_bad      = 1'b0;
  bit     e_start    = 1'b0;
  code_t  e_code     = '0;
  bit     e_err      = 1'b0;
  bit     e_ovf      = 1'b0;

  // observation counters for the directed literal checks
  msg_t   obs_word;
  int     obs_n, obs_first_n, obs_bad_n, err_n, ovf_n, start_n;
  int     t_start0, t_err0;
  code_t  last_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_obs();
    obs_word = '0; obs_n = 0; obs_first_n = 0; obs_bad_n = 0;
    err_n = 0; ovf_n = 0; start_n = 0; t_start0 = -1; t_err0 = -1;
    last_code = '0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit s, input bit rn,
                            input bit dn, input msg_t dd, input metric_t dm);
    bit    complete, waiting, draining, go;
    code_t frame;
    complete = 1'b0; go = 1'b0; frame = '0;
    if (!rn) begin
      m_idx = 0; m_bits = '0; m_held_v = 1'b0; m_held = '0; m_wait_age = -1;
      m_drain_q.delete(); m_first = 1'b0; m_bad = 1'b0;
      e_start = 1'b0; e_code = '0; e_err = 1'b0; e_ovf = 1'b0;
      return;
    end
    e_start = 1'b0; e_err = 1'b0; e_ovf = 1'b0;
    waiting  = (m_wait_age >= 0);
    draining = (m_drain_q.size() != 0);
    if (v) begin
      if (s) begin
        if (m_idx != 0) e_err = 1'b1;
        m_bits = '0; m_bits[0] = b; m_idx = 1;
      end else begin
        m_bits[m_idx] = b;
        if (m_idx == CODE_LEN - 1) begin
          complete = 1'b1; frame = m_bits; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
    if (waiting) begin
      if (dn) begin
        m_wait_age = -1;
        for (int i = MSG_LEN - 1; i >= 0; i--) m_drain_q.push_back(dd[i]);
        m_first = 1'b1;
        m_bad   = (dm > ERR_THRESH_DEF);
      end else begin
        m_wait_age++;
        if (m_wait_age == DEC_TIMEOUT_DEF) begin
          e_err = 1'b1; m_wait_age = -1;
        end
      end
    end else if (draining) begin
      void'(m_drain_q.pop_front());
      m_first = 1'b0;
      go = (m_drain_q.size() == 0) && m_held_v;
    end else begin
      go = m_held_v;
    end
    if (go) begin
      e_start = 1'b1; e_code = m_held; m_held_v = 1'b0; m_wait_age = 0;
    end
    if (complete) begin
      if (!m_held_v) begin
        m_held = frame; m_held_v = 1'b1;
      end else begin
        e_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    bit e_valid, e_bit, e_first;
    e_valid = (m_drain_q.size() != 0);
    e_bit   = e_valid ? m_drain_q[0] : 1'b0;
    e_first = e_valid && m_first;
    chk("dec_start", 32'(bus.dec_start), 32'(e_start));
    chk("dec_code",  32'(bus.dec_code),  32'(e_code));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_bit",   32'(bus.out_bit),   32'(e_bit));
    chk("out_first", 32'(bus.out_first), 32'(e_first));
    chk("bad_frame", 32'(bus.bad_frame), 32'(e_first && m_bad));
    chk("frame_err", 32'(bus.frame_err), 32'(e_err));
    chk("overflow",  32'(bus.overflow),  32'(e_ovf));
    chk("busy",      32'(bus.busy),
        32'((m_wait_age >= 0) || e_valid || m_held_v));
  endtask

  task automatic cycle(input bit v, input bit b, input bit s);
    bit dn;
    if (bus.dec_start === 1'b1) st_cd = st_lat;
    dn = (st_cd == 1) || st_force;
    if (st_cd > 0) st_cd--;
    if (!st_rst_n) st_cd = 0;
    st_force = 1'b0;
    bus.in_valid   = v;
    bus.in_bit     = b;
    bus.frame_sync = s;
    bus.dec_done   = dn;
    bus.dec_data   = st_data;
    bus.dec_metric = st_met;
    reset          = st_rst_n;
    model_step(v, b, s, st_rst_n, dn, st_data, st_met);
    @(negedge clk1);
    cyc++;
    compare_all();
    if (bus.out_valid === 1'b1) begin
      obs_word = {obs_word[MSG_LEN-2:0], bus.out_bit};
      obs_n++;
    end
    if (bus.out_first === 1'b1) obs_first_n++;
    if (bus.bad_frame === 1'b1) obs_bad_n++;
    if (bus.frame_err === 1'b1) begin
      if (err_n == 0) t_err0 = cyc;
      err_n++;
    end
    if (bus.overflow === 1'b1) ovf_n++;
    if (bus.dec_start === 1'b1) begin
      if (start_n == 0) t_start0 = cyc;
      start_n++;
      last_code = bus.dec_code;
    end
  endtask

  task automatic send_frame(input code_t code);
    for (int i = 0; i < CODE_LEN; i++) cycle(1'b1, code[i], i == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    bit v, s, b;
    int r;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.frame_sync = 1'b0;
    bus.dec_done = 1'b0; bus.dec_data = '0; bus.dec_metric = '0;
    clr_obs();
    @(negedge clk1);

    // reset state
    st_rst_n = 1'b0;
    idle(3);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dec_code",  32'(bus.dec_code),  32'd0);
    st_rst_n = 1'b1;
    idle(1);

    // basic frame, dispatch latency and serialization
    st_lat = 2; st_data = 7'b1011001; st_met = 4'd1;
    clr_obs();
    send_frame(14'h2A5C);
    n = 0;
    while (bus.dec_start !== 1'b1 && n < 10) begin idle(1); n++; end
    chk("t1_start_latency", 32'(n), 32'd1);
    chk("t1_dec_code", 32'(bus.dec_code), 32'h2A5C);
    idle(14);
    chk("t1_word",    32'(obs_word),    32'b1011001);
    chk("t1_nbits",   32'(obs_n),       32'd7);
    chk("t1_first_n", 32'(obs_first_n), 32'd1);
    chk("t1_bad_n",   32'(obs_bad_n),   32'd0);

    // high metric flags the frame on its first bit only
    st_met = 4'd5;
    clr_obs();
    send_frame(14'h2A5C);
    idle(16);
    chk("t2_bad_n",   32'(obs_bad_n),   32'd1);
    chk("t2_first_n", 32'(obs_first_n), 32'd1);
    chk("t2_nbits",   32'(obs_n),       32'd7);

    // sync slip at idx 6, then a clean frame
    st_lat = 3; st_data = 7'h2A; st_met = 4'd0;
    clr_obs();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'(i & 1), i == 0);
    send_frame(14'h1234);
    n = 0;
    while (bus.dec_start !== 1'b1 && n < 10) begin idle(1); n++; end
    chk("t3_err_n", 32'(err_n), 32'd1);
    chk("t3_code",  32'(bus.dec_code), 32'h1234);
    idle(20);

    // decoder never answers: timeout, then the held frame goes out
    st_lat = -1;
    clr_obs();
    send_frame(14'h0ABC);
    send_frame(14'h3D21);
    n = 0;
    while (err_n == 0 && n < 40) begin idle(1); n++; end
    chk("t4_timeout_cycles", 32'(t_err0 - t_start0), 32'd15);
    n = 0;
    while (start_n < 2 && n < 5) begin idle(1); n++; end
    chk("t4_starts", 32'(start_n), 32'd2);
    chk("t4_held_code", 32'(last_code), 32'h3D21);
    idle(20);

    // slowest legal decoder: fourth back-to-back frame overflows
    st_lat = 15; st_data = 7'h33;
    clr_obs();
    send_frame(14'h1111);
    send_frame(14'h2222);
    send_frame(14'h3333);
    send_frame(14'h0444);
    idle(60);
    chk("t5_ovf_n",   32'(ovf_n),     32'd1);
    chk("t5_starts",  32'(start_n),   32'd3);
    chk("t5_last",    32'(last_code), 32'h3333);

    // reset during DRAIN, then a stray dec_done
    st_lat = 2; st_data = 7'h4B; st_met = 4'd0;
    clr_obs();
    send_frame(14'h0F0F);
    n = 0;
    while (bus.out_first !== 1'b1 && n < 20) begin idle(1); n++; end
    idle(2);
    st_rst_n = 1'b0;
    idle(1);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    st_rst_n = 1'b1;
    clr_obs();
    st_force = 1'b1;
    idle(10);
    chk("t6_stray_bits", 32'(obs_n), 32'd0);
    chk("t6_stray_busy", 32'(bus.busy), 32'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 19));
      st_lat   = (r == 19) ? -1 : r + 1;
      st_data  = 7'($urandom);
      st_met   = 4'($urandom);
      st_force = ($urandom_range(0, 63) == 0);
      st_rst_n = ($urandom_range(0, 999) != 0);
      v = ($urandom_range(0, 7) != 0);
      s = v && ($urandom_range(0, 29) == 0);
      b = 1'($urandom_range(0, 1));
      cycle(v, b, s);
    end
    st_rst_n = 1'b1;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
